// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the instruction-fetch PC block: widths, reset PC,
// FSM state encoding and the registered instruction payload.
// FETCH_MISALIGN_TRAP_EN adds the TRAP state.
package fetch_pc_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd3
`endif
    } fetch_state_e;

    // Instruction handed to decode, together with its PC
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] word;
    } fetch_inst_t;

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch bus bundle: redirect input, instruction-memory request/response and
// the decode-side instruction handshake.
// master: fetch_pc side; slave: the surrounding pipeline / memory.
// fetch_exc exists only with FETCH_MISALIGN_TRAP_EN.
interface fetch_pc_if;
    import fetch_pc_pkg::*;

    logic            jump_en;
    logic [XLEN-1:0] jump_addr;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_exc;
`endif

    modport master (
        input  jump_en, jump_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
        , output fetch_exc
`endif
    );

    modport slave (
        output jump_en, jump_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
        , input fetch_exc
`endif
    );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: redirect target (bit 0 cleared), pc+4, or hold.
// Ports: pc (current), jump_en/jump_addr (redirect), advance (instruction
// consumed), next_pc_c (selected next PC). Redirect has priority over advance.
module fetch_pc_next
    import fetch_pc_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc_c
);

    always_comb begin
        next_pc_c = pc;
        if (jump_en) begin
            next_pc_c = jump_addr & ~XLEN'(1);
        end else if (advance) begin
            next_pc_c = pc + XLEN'(4);  // wraps modulo 2^64
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Instruction fetch PC sequencer: issues one memory request at a time, holds
// the returned word for decode, and handles redirects including discarding a
// response that belongs to a request made before the redirect.
// Ports: clk, rst_n (async active-low), bus (fetch_pc_if.master).
// Parameter RESET_PC: first fetch address after reset.
// Define FETCH_MISALIGN_TRAP_EN to trap on redirects with jump_addr[1:0] != 0.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    fetch_inst_t     out_q, out_d;
    logic            req_fire_c;
    logic            advance_c;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            exc_q, exc_d;
`endif

    fetch_pc_next u_next (
        .pc        (pc_q),
        .jump_en   (bus.jump_en),
        .jump_addr (bus.jump_addr),
        .advance   (advance_c),
        .next_pc_c (pc_d)
    );

    // Next-state, drop tracking and output-register updates
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        out_d        = out_q;
        inst_valid_d = inst_valid_q;
        advance_c    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        exc_d        = exc_q;
`endif
        req_fire_c   = (state_q == ST_REQ) && req_valid_q && bus.imem_req_ready;

        case (state_q)
            ST_REQ: begin
                if (req_fire_c) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    out_d.pc     = pc_q;
                    out_d.word   = bus.imem_rsp_data;
                    inst_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_valid_q && bus.inst_ready) begin
                    advance_c    = 1'b1;
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
            end
`endif
            default: state_d = ST_REQ;
        endcase

        // The stale response arriving retires the pending drop
        if (drop_q && bus.imem_rsp_valid) drop_d = 1'b0;

        // Redirect overrides everything; an in-flight request must be drained
        if (bus.jump_en) begin
            inst_valid_d = 1'b0;
            state_d      = ST_REQ;
            if (req_fire_c || ((state_q == ST_WAIT) && !bus.imem_rsp_valid)) drop_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_d = 1'b0;
            if (bus.jump_addr[1:0] != 2'b00) begin
                state_d  = ST_TRAP;
                exc_d    = 1'b1;
                out_d.pc = bus.jump_addr;
            end
`endif
        end

        // No new request while an old response is still owed
        req_valid_d = (state_d == ST_REQ) && !drop_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            out_q        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            out_q        <= out_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            exc_q        <= exc_d;
`endif
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = out_q.word;
    assign bus.inst_pc        = out_q.pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_exc      = exc_q;
`endif

endmodule
